mux8x1_reg: RTL and testbench

- 8-to-1 multiplexer, the bit-slice selector of the shifter units (SLL/SRL/rotate) in the 8-bit single-cycle processor datapath.
- Provides a zero-latency combinational output, which the shifters use, and a registered copy with a valid flag for pipelined or diagnostic use.
- Port order on the combinational side is fixed: OUT, IN0..IN7, SEL. This allows positional instantiation by the shifter modules.

---
 rtl/mux8x1_reg.sv | 96 +++++++++
 tb/tb_mux8x1_reg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux8x1_reg.sv
// 8-to-1 bit-slice selector with a zero-latency output and a registered copy plus valid flag.
// Optional registered even-parity output OUT_PAR is enabled by defining MUX8X1_PARITY_EN.
module mux8x1_reg #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] OUT,
  input  logic [WIDTH-1:0] IN0,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  input  logic [WIDTH-1:0] IN3,
  input  logic [WIDTH-1:0] IN4,
  input  logic [WIDTH-1:0] IN5,
  input  logic [WIDTH-1:0] IN6,
  input  logic [WIDTH-1:0] IN7,
  input  logic [2:0]       SEL,
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             IN_VALID,
  output logic [WIDTH-1:0] OUT_Q,
  output logic [2:0]       SEL_Q,
  output logic             OUT_VALID
`ifdef MUX8X1_PARITY_EN
  ,
  output logic             OUT_PAR
`endif
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       sel_q, sel_d;
  logic             valid_q, valid_d;

  // The default arm only matters in simulation, where an unknown SEL forces zeros.
  always_comb begin
    OUT = '0;
    case (SEL)
      3'd0:    OUT = IN0;
      3'd1:    OUT = IN1;
      3'd2:    OUT = IN2;
      3'd3:    OUT = IN3;
      3'd4:    OUT = IN4;
      3'd5:    OUT = IN5;
      3'd6:    OUT = IN6;
      3'd7:    OUT = IN7;
      default: OUT = '0;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = IN_VALID;
    if (IN_VALID) begin
      data_d = OUT;
      sel_d  = SEL;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign OUT_Q     = data_q;
  assign SEL_Q     = sel_q;
  assign OUT_VALID = valid_q;

`ifdef MUX8X1_PARITY_EN
  logic par_q, par_d;

  // Parity follows the same capture qualification as the data register.
  always_comb begin
    par_d = par_q;
    if (IN_VALID) begin
      par_d = ^OUT;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign OUT_PAR = par_q;
`endif

endmodule

// File: tb/tb_mux8x1_reg.sv
// Scoreboard bench for mux8x1_reg: a 1-bit instance for the select sweep, an 8-bit one for the registered path.
module tb_mux8x1_reg;

  logic clk;
  logic clk_en;
  logic rst_n;

  // 8-bit instance signals
  logic [7:0] in_data [8];
  logic [2:0] sel;
  logic       in_valid;
  logic [7:0] out_c;
  logic [7:0] out_q;
  logic [2:0] sel_q;
  logic       out_valid;
`ifdef MUX8X1_PARITY_EN
  logic       out_par;
`endif

  // 1-bit instance signals
  logic [7:0] bits1;
  logic [2:0] sel1;
  logic       out1;
  logic       out1_q;
  logic [2:0] sel1_q;
  logic       out1_valid;
`ifdef MUX8X1_PARITY_EN
  logic       out1_par;
`endif

  int n_compared;
  int n_mismatched;

  typedef struct packed {
    logic [7:0] out_q;
    logic [2:0] sel_q;
    logic       valid;
    logic       par;
  } exp_t;

  exp_t sb [$];

  logic [7:0] hold_data;
  logic [2:0] hold_sel;
  logic       hold_par;

  mux8x1_reg #(.WIDTH(8)) u_dut8 (
    .OUT(out_c),
    .IN0(in_data[0]), .IN1(in_data[1]), .IN2(in_data[2]), .IN3(in_data[3]),
    .IN4(in_data[4]), .IN5(in_data[5]), .IN6(in_data[6]), .IN7(in_data[7]),
    .SEL(sel),
    .CLK(clk),
    .RESETN(rst_n),
    .IN_VALID(in_valid),
    .OUT_Q(out_q),
    .SEL_Q(sel_q),
    .OUT_VALID(out_valid)
`ifdef MUX8X1_PARITY_EN
    ,
    .OUT_PAR(out_par)
`endif
  );

  mux8x1_reg #(.WIDTH(1)) u_dut1 (
    .OUT(out1),
    .IN0(bits1[0]), .IN1(bits1[1]), .IN2(bits1[2]), .IN3(bits1[3]),
    .IN4(bits1[4]), .IN5(bits1[5]), .IN6(bits1[6]), .IN7(bits1[7]),
    .SEL(sel1),
    .CLK(clk),
    .RESETN(rst_n),
    .IN_VALID(1'b0),
    .OUT_Q(out1_q),
    .SEL_Q(sel1_q),
    .OUT_VALID(out1_valid)
`ifdef MUX8X1_PARITY_EN
    ,
    .OUT_PAR(out1_par)
`endif
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected registered state, then compare after the edge.
  task automatic applyStimulus(input logic v, input logic [2:0] s);
    exp_t e;
    exp_t got;
    in_valid = v;
    sel      = s;
    if (v) begin
      hold_data = in_data[s];
      hold_sel  = s;
      hold_par  = ^in_data[s];
    end
    e.out_q = hold_data;
    e.sel_q = hold_sel;
    e.valid = v;
    e.par   = hold_par;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      checkOutput("out_q", {24'd0, out_q}, {24'd0, got.out_q});
      checkOutput("sel_q", {29'd0, sel_q}, {29'd0, got.sel_q});
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, got.valid});
`ifdef MUX8X1_PARITY_EN
      checkOutput("out_par", {31'd0, out_par}, {31'd0, got.par});
`endif
    end
  endtask

  initial begin
    logic exp_bits [8];
    logic [7:0] rv;
    n_compared   = 0;
    n_mismatched = 0;
    clk_en    = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sel       = 3'd0;
    sel1      = 3'd0;
    hold_data = 8'd0;
    hold_sel  = 3'd0;
    hold_par  = 1'b0;
    for (int i = 0; i < 8; i++) in_data[i] = 8'h10 + 8'(i);
    bits1     = 8'b0100_1101;
    exp_bits  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    #3;

    checkOutput("rst_out_q", {24'd0, out_q}, 32'd0);
    checkOutput("rst_sel_q", {29'd0, sel_q}, 32'd0);
    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);

    // Combinational sweep on the 1-bit instance with the clock stopped
    for (int i = 0; i < 8; i++) begin
      sel1 = 3'(i);
      #1;
      checkOutput($sformatf("w1_sel%0d", i), {31'd0, out1}, {31'd0, exp_bits[i]});
    end

    #2;
    rst_n  = 1'b1;
    clk_en = 1'b1;
    #2;

    in_valid = 1'b1;
    sel      = 3'd5;
    #1;
    checkOutput("comb_sel5", {24'd0, out_c}, 32'h15);
    applyStimulus(1'b1, 3'd5);
    checkOutput("cap_sel5", {24'd0, out_q}, 32'h15);

    applyStimulus(1'b1, 3'd2);
    in_valid = 1'b0;
    sel      = 3'd6;
    #1;
    checkOutput("comb_sel6", {24'd0, out_c}, 32'h16);
    applyStimulus(1'b0, 3'd6);
    checkOutput("hold_12", {24'd0, out_q}, 32'h12);

    // Back-to-back and gapped captures with random data
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 8; i++) in_data[i] = 8'($urandom);
      applyStimulus(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
    end

    for (int i = 0; i < 8; i++) in_data[i] = 8'h10 + 8'(i);
    applyStimulus(1'b1, 3'd7);
    checkOutput("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1;
    sel      = 3'd1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_q", {24'd0, out_q}, 32'd0);
    checkOutput("mid_rst_sel_q", {29'd0, sel_q}, 32'd0);
    checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    hold_data = 8'd0;
    hold_sel  = 3'd0;
    hold_par  = 1'b0;
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'd3);
    checkOutput("post_rst_cap", {24'd0, out_q}, 32'h13);

    in_valid = 1'b0;
    sel      = 3'bxx1;
    #1;
    if ($isunknown(sel)) begin
      checkOutput("sel_x", {24'd0, out_c}, 32'd0);
    end else begin
      rv = in_data[sel];
      checkOutput("sel_x_2state", {24'd0, out_c}, {24'd0, rv});
    end
    sel = 3'd0;

    in_data[3] = 8'b0000_0111;
    applyStimulus(1'b1, 3'd3);
`ifdef MUX8X1_PARITY_EN
    checkOutput("par_07", {31'd0, out_par}, 32'd1);
`endif
    in_data[4] = 8'h03;
    applyStimulus(1'b1, 3'd4);
`ifdef MUX8X1_PARITY_EN
    checkOutput("par_03", {31'd0, out_par}, 32'd0);
`endif
    applyStimulus(1'b0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
